// File: rtl/muldiv_pkg.sv
// Shared types for the sequential multiply/divide unit.
package muldiv_pkg;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter runs 0..width; the final count marks the result transfer cycle.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring trial-subtract divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  op_e                  op,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   upper;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // upper WIDTH+1 bits of {rem, quo} after the left shift
    upper    = acc[2*WIDTH-1:WIDTH-1];
    diff     = upper[WIDTH-1:0] - opnd;
    acc_next = acc;
    if (op == OP_MUL) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else if (upper >= {1'b0, opnd}) begin
      acc_next = {diff, acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {upper[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_mul_div.sv
// Multi-cycle multiplier/divider with valid/ready handshakes.
// MULDIV_SIGNED_EN adds the signed_op port for two's-complement operands.
module seq_mul_div
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               op,
`ifdef MULDIV_SIGNED_EN
  input  logic               signed_op,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned W2 = 2 * WIDTH;

  state_e            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [W2-1:0]     acc;
  logic [W2-1:0]     acc_step;
  logic [W2-1:0]     final_c;
  logic [WIDTH-1:0]  opnd;
  logic [WIDTH-1:0]  mag_a, mag_b;
  op_e               op_q;
  op_e               op_in;
  logic              dbz_q;
  logic              accept_c;
  logic              iterate_c;
  logic              finish_c;

  assign op_in = op_e'(op);

`ifdef MULDIV_SIGNED_EN
  logic neg_a_c, neg_b_c;
  logic neg_a_q, neg_res_q;

  assign neg_a_c = signed_op & a[WIDTH-1];
  assign neg_b_c = signed_op & b[WIDTH-1];
  assign mag_a   = neg_a_c ? WIDTH'(-a) : a;
  assign mag_b   = neg_b_c ? WIDTH'(-b) : b;
`else
  assign mag_a = a;
  assign mag_b = b;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op       (op_q),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_step)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept_c  = 1'b0;
    iterate_c = 1'b0;
    finish_c  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept_c  = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == CW'(WIDTH)) begin
          finish_c  = 1'b1;
          state_nxt = DONE;
        end else begin
          iterate_c = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sign fix-up of the unsigned core result on the transfer into DONE
  always_comb begin
    final_c = acc;
`ifdef MULDIV_SIGNED_EN
    if (op_q == OP_MUL) begin
      if (neg_res_q) final_c = W2'(-acc);
    end else begin
      final_c[WIDTH-1:0]  = neg_res_q ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
      final_c[W2-1:WIDTH] = neg_a_q ? WIDTH'(-acc[W2-1:WIDTH]) : acc[W2-1:WIDTH];
      if (dbz_q) final_c[WIDTH-1:0] = '1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      op_q        <= OP_MUL;
      dbz_q       <= 1'b0;
      out_valid   <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept_c) begin
        cnt   <= '0;
        op_q  <= op_in;
        opnd  <= (op_in == OP_MUL) ? mag_a : mag_b;
        acc   <= {{WIDTH{1'b0}}, (op_in == OP_MUL) ? mag_b : mag_a};
        dbz_q <= (op_in == OP_DIV) && (b == '0);
      end
      if (iterate_c) begin
        acc <= acc_step;
        cnt <= cnt + CW'(1);
      end
      if (finish_c) begin
        out_valid   <= 1'b1;
        result      <= final_c;
        div_by_zero <= dbz_q;
      end
      if (state == DONE && out_ready) out_valid <= 1'b0;
    end
  end

`ifdef MULDIV_SIGNED_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_a_q   <= 1'b0;
      neg_res_q <= 1'b0;
    end else if (accept_c) begin
      neg_a_q   <= neg_a_c;
      neg_res_q <= neg_a_c ^ neg_b_c;
    end
  end
`endif

endmodule

// File: tb/tb_seq_mul_div.sv
// Scoreboard bench for seq_mul_div: driver pushes expected results, monitor checks them.
module tb_seq_mul_div;

  localparam int unsigned WIDTH = 8;

  typedef struct {
    int unsigned acc_edge;
    logic [15:0] res;
    logic        dbz;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [7:0]  a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        div_by_zero;
`ifdef MULDIV_SIGNED_EN
  logic        signed_op;
`endif

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          hold = 0;

  seq_mul_div #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
`ifdef MULDIV_SIGNED_EN
    .signed_op   (signed_op),
`endif
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values
  function automatic void model(input logic o, input logic [7:0] x, input logic [7:0] y,
                                input logic s, output logic [15:0] r, output logic d);
    int sx, sy, q, rm;
    sx = s ? int'($signed(x)) : int'(x);
    sy = s ? int'($signed(y)) : int'(y);
    d  = o && (y == 8'd0);
    if (!o) begin
      r = 16'(sx * sy);
    end else begin
      if (y == 8'd0) begin
        q  = -1;
        rm = sx;
      end else begin
        q  = sx / sy;
        rm = sx % sy;
      end
      r = {8'(rm), 8'(q)};
    end
  endfunction

  task automatic issue_exp(input logic o, input logic [7:0] x, input logic [7:0] y,
                           input logic s, input logic [15:0] er, input logic ed);
    int guard = 0;
    @(negedge clk);
    while (!in_ready) begin
      in_valid = 1'($urandom);
      op       = 1'($urandom);
      a        = 8'($urandom);
      b        = 8'($urandom);
      guard++;
      if (guard > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, expected 1", guard);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
`ifdef MULDIV_SIGNED_EN
    signed_op = s;
`endif
    sb.push_back('{cyc + 1, er, ed});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic o, input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [15:0] r;
    logic        d;
    model(o, x, y, s, r, d);
    issue_exp(o, x, y, s, r, d);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: samples 2 time units after each rising edge
  initial begin : monitor
    logic        prev_ov;
    logic [15:0] prev_res;
    logic        prev_dbz;
    logic        exp_rdy;
    prev_ov   = 1'b0;
    prev_res  = '0;
    prev_dbz  = 1'b0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        prev_ov   = 1'b0;
        out_ready = 1'($urandom);
      end else begin
        exp_rdy = !(sb.size() > 0 && sb[0].acc_edge <= cyc);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (out_valid && !prev_ov) begin
          if (sb.size() == 0) chk("spurious_valid", 32'(out_valid), 32'd0);
          else chk("latency_edge", cyc, sb[0].acc_edge + WIDTH + 1);
        end
        if (out_valid && prev_ov) begin
          chk("hold_result", 32'(result), 32'(prev_res));
          chk("hold_dbz", 32'(div_by_zero), 32'(prev_dbz));
        end
        if (!out_valid && sb.size() > 0 && cyc > sb[0].acc_edge + WIDTH + 1) begin
          chk("result_timeout", 32'(out_valid), 32'd1);
          void'(sb.pop_front());
        end
        if (out_valid && hold > 0) begin
          out_ready = 1'b0;
          hold--;
        end else begin
          out_ready = ($urandom % 4) != 0;
        end
        if (out_valid && out_ready && sb.size() > 0) begin
          chk("result", 32'(result), 32'(sb[0].res));
          chk("div_by_zero", 32'(div_by_zero), 32'(sb[0].dbz));
          void'(sb.pop_front());
        end
        prev_ov  = out_valid;
        prev_res = result;
        prev_dbz = div_by_zero;
      end
    end
  end

  initial begin : driver
    reset    = 1'b1;
    in_valid = 1'b0;
    op       = 1'b0;
    a        = '0;
    b        = '0;
`ifdef MULDIV_SIGNED_EN
    signed_op = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    issue_exp(1'b0, 8'd13, 8'd11, 1'b0, 16'h008F, 1'b0);
    issue_exp(1'b1, 8'd200, 8'd7, 1'b0, 16'h041C, 1'b0);
    issue_exp(1'b1, 8'd255, 8'd255, 1'b0, 16'h0001, 1'b0);
    issue_exp(1'b1, 8'd37, 8'd0, 1'b0, 16'h25FF, 1'b1);
    wait_drain();

    hold = 5;
    issue_exp(1'b0, 8'd200, 8'd3, 1'b0, 16'h0258, 1'b0);
    wait_drain();

    // Reset mid-BUSY: the operation in flight must vanish
    issue(1'b0, 8'd99, 8'd77, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_dbz", 32'(div_by_zero), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    issue_exp(1'b0, 8'd255, 8'd255, 1'b0, 16'hFE01, 1'b0);
    wait_drain();

`ifdef MULDIV_SIGNED_EN
    issue_exp(1'b0, 8'hF9, 8'd3, 1'b1, 16'hFFEB, 1'b0);
    issue_exp(1'b1, 8'hF9, 8'd2, 1'b1, 16'hFFFD, 1'b0);
    issue_exp(1'b1, 8'h80, 8'hFF, 1'b1, 16'h0080, 1'b0);
    issue_exp(1'b1, 8'hF9, 8'd0, 1'b1, 16'hF9FF, 1'b1);
    wait_drain();
`endif

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic       rs;
      ra = 8'($urandom);
      rb = ($urandom % 8 == 0) ? 8'd0 : 8'($urandom);
`ifdef MULDIV_SIGNED_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      issue(1'($urandom), ra, rb, rs);
    end
    wait_drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
